// File: rtl/serial_master_port_p.sv
// Parametrised bit-serial bus master port.
// Takes a transfer request from the master core (address, direction, burst length),
// wins the shared bus, and sends the device-select and address bits MSB first. It then
// shifts write beats out or read beats in. A stalled device-select phase times out,
// backs off and is retried a bounded number of times. Status is reported with m_done/m_err.
module serial_master_port_p #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 16,
  parameter int DEV_W     = 4,
  parameter int TIMEOUT   = 64,
  parameter int MAX_RETRY = 3,
  parameter int BURST_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  output logic               mode,
  output logic               wr_bus,
  input  logic               rd_bus,
  input  logic               ack,
  output logic               master_valid,
  input  logic               slave_ready,
  output logic               master_ready,
  input  logic               slave_valid,
  output logic               breq,
  input  logic               bgrant,
  input  logic               split,
  input  logic               m_start,
  input  logic               m_mode,
  input  logic [ADDR_W-1:0]  m_addr,
  input  logic [BURST_W-1:0] m_burst_len,
  input  logic [DATA_W-1:0]  m_wr_data,
  output logic               m_wr_ack,
  output logic [DATA_W-1:0]  m_rd_data,
  output logic               m_rd_valid,
  output logic               m_busy,
  output logic               m_done,
  output logic [1:0]         m_err
);

  localparam int CNT_W = $clog2(((ADDR_W > DATA_W) ? ADDR_W : DATA_W) + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 2);

  localparam logic [CNT_W-1:0] DEV_LAST  = CNT_W'(DEV_W - 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_NACK = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_FETCH, S_DEV, S_ADDR, S_LOAD,
    S_WR_DATA, S_RD_DATA, S_SPLIT, S_BACKOFF, S_DONE
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  addr_lat;   // address kept for every retry attempt
  logic [ADDR_W-1:0]  addr_sr;
  logic [BURST_W-1:0] len_lat;
  logic [BURST_W-1:0] beat_cnt;   // beats already finished; last beat when equal to len_lat
  logic [DATA_W-1:0]  data_sr;    // write shift-out or read shift-in, never both at once
  logic [CNT_W-1:0]   bit_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [RTY_W-1:0]   retry_cnt;

  // Bus-side strobes decoded straight from the state register
  assign m_busy       = (state != S_IDLE);
  assign breq         = !(state inside {S_IDLE, S_BACKOFF, S_DONE});
  assign master_valid = (state inside {S_DEV, S_ADDR, S_WR_DATA});
  assign master_ready = (state == S_RD_DATA);
  assign m_wr_ack     = (state == S_LOAD);
  assign m_done       = (state == S_DONE);
  assign wr_bus       = (state inside {S_DEV, S_ADDR}) ? addr_sr[ADDR_W-1] :
                        (state == S_WR_DATA)           ? data_sr[DATA_W-1] : 1'b0;

  // Transfer sequencer: counters, shift registers and status all advance here
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      mode       <= 1'b0;
      addr_lat   <= '0;
      addr_sr    <= '0;
      len_lat    <= '0;
      beat_cnt   <= '0;
      data_sr    <= '0;
      bit_cnt    <= '0;
      tmo_cnt    <= '0;
      retry_cnt  <= '0;
      m_rd_data  <= '0;
      m_rd_valid <= 1'b0;
      m_err      <= ERR_OK;
    end else begin
      m_rd_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (m_start) begin
            addr_lat  <= m_addr;
            mode      <= m_mode;
            len_lat   <= m_burst_len;
            retry_cnt <= '0;
            m_err     <= ERR_OK;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (bgrant) state <= S_FETCH;
        end
        S_FETCH: begin
          // every attempt restarts from the latched address, not the live m_addr
          addr_sr  <= addr_lat;
          bit_cnt  <= '0;
          tmo_cnt  <= '0;
          beat_cnt <= '0;
          state    <= S_DEV;
        end
        S_DEV: begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          if (slave_ready) begin
            addr_sr <= addr_sr << 1;
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
          // a completed device select wins over a timeout on the same cycle
          if (slave_ready && bit_cnt == DEV_LAST) begin
            if (ack) begin
              state <= S_ADDR;
            end else begin
              m_err <= ERR_NACK;
              state <= S_DONE;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            state <= S_BACKOFF;
          end
        end
        S_ADDR: begin
          if (slave_ready) begin
            addr_sr <= addr_sr << 1;
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == ADDR_LAST) begin
              bit_cnt <= '0;
              state   <= mode ? S_LOAD : S_RD_DATA;
            end
          end
        end
        S_LOAD: begin
          data_sr <= m_wr_data;
          state   <= S_WR_DATA;
        end
        S_WR_DATA: begin
          if (slave_ready) begin
            data_sr <= data_sr << 1;
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              if (beat_cnt == len_lat) begin
                m_err <= ERR_OK;
                state <= S_DONE;
              end else begin
                beat_cnt <= beat_cnt + BURST_W'(1);
                state    <= S_LOAD;
              end
            end
          end
        end
        S_RD_DATA: begin
          // split parks the transfer before any bit is captured this cycle
          if (split) begin
            state <= S_SPLIT;
          end else if (slave_valid) begin
            data_sr <= {data_sr[DATA_W-2:0], rd_bus};
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == DATA_LAST) begin
              m_rd_data  <= {data_sr[DATA_W-2:0], rd_bus};
              m_rd_valid <= 1'b1;
              bit_cnt    <= '0;
              if (beat_cnt == len_lat) begin
                m_err <= ERR_OK;
                state <= S_DONE;
              end else begin
                beat_cnt <= beat_cnt + BURST_W'(1);
              end
            end
          end
        end
        S_SPLIT: begin
          if (!split) state <= S_RD_DATA;
        end
        S_BACKOFF: begin
          if (retry_cnt == RTY_MAX) begin
            m_err <= ERR_TMO;
            state <= S_DONE;
          end else begin
            retry_cnt <= retry_cnt + RTY_W'(1);
            state     <= S_REQ;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_master_port_p.sv
// Self-checking bench for serial_master_port_p: directed scenarios plus randomized
// transfers, checked against a transaction-level model of the serial bus traffic.
module tb_serial_master_port_p;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 16;
  localparam int DEV_W     = 4;
  localparam int TIMEOUT   = 64;
  localparam int MAX_RETRY = 3;
  localparam int BURST_W   = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               mode, wr_bus, master_valid, master_ready, breq;
  logic               rd_bus = 1'b0, ack = 1'b0, slave_ready = 1'b0, slave_valid = 1'b0;
  logic               bgrant = 1'b0, split = 1'b0, m_start = 1'b0, m_mode = 1'b0;
  logic [ADDR_W-1:0]  m_addr = '0;
  logic [BURST_W-1:0] m_burst_len = '0;
  logic [DATA_W-1:0]  m_wr_data = '0;
  logic               m_wr_ack, m_rd_valid, m_busy, m_done;
  logic [DATA_W-1:0]  m_rd_data;
  logic [1:0]         m_err;

  serial_master_port_p #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEV_W(DEV_W),
    .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY), .BURST_W(BURST_W)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .wr_bus(wr_bus), .rd_bus(rd_bus), .ack(ack),
    .master_valid(master_valid), .slave_ready(slave_ready), .master_ready(master_ready),
    .slave_valid(slave_valid), .breq(breq), .bgrant(bgrant), .split(split),
    .m_start(m_start), .m_mode(m_mode), .m_addr(m_addr), .m_burst_len(m_burst_len),
    .m_wr_data(m_wr_data), .m_wr_ack(m_wr_ack), .m_rd_data(m_rd_data),
    .m_rd_valid(m_rd_valid), .m_busy(m_busy), .m_done(m_done), .m_err(m_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // stimulus knobs
  int grant_pct, rdy_pct, val_pct, split_pct, rdy_hold0, rst_at_bit;
  bit split_at3;

  // transaction data and observations
  logic [DATA_W-1:0] wdata[$];
  logic [DATA_W-1:0] rd_exp[$];
  logic [DATA_W-1:0] rd_got[$];
  bit                rd_src[$];
  bit                bits_q[$];
  bit                exp_q[$];
  int                wr_acks, backoffs, done_cyc, stall_bad, split_bad, split_cyc;
  bit                done_seen, rst_done;
  logic [1:0]        got_err;
  logic [18:0]       rst_snap;

  task automatic nominal();
    grant_pct = 100; rdy_pct = 100; val_pct = 100; split_pct = 0;
    rdy_hold0 = 0; rst_at_bit = 0; split_at3 = 1'b0;
  endtask

  // Reference: what the bus must carry, from address, direction, ack and beats.
  task automatic model(input bit md, input logic [ADDR_W-1:0] a, input bit ack_v);
    exp_q.delete();
    rd_src.delete();
    for (int i = ADDR_W - 1; i >= 0; i--)
      if (ack_v || i >= ADDR_W - DEV_W) exp_q.push_back(a[i]);
    if (md && ack_v)
      foreach (wdata[k]) for (int i = DATA_W - 1; i >= 0; i--) exp_q.push_back(wdata[k][i]);
    if (!md)
      foreach (rd_exp[k]) for (int i = DATA_W - 1; i >= 0; i--) rd_src.push_back(rd_exp[k][i]);
  endtask

  // cycle of m_done with bgrant/ready/valid always high, counting the m_start cycle as 0
  function automatic int lat_model(input bit md, input int beats);
    return 3 + ADDR_W + beats * (DATA_W + (md ? 1 : 0));
  endfunction

  function automatic int bit_diffs();
    int d = 0;
    if (bits_q.size() != exp_q.size()) return -1;
    foreach (bits_q[i]) if (bits_q[i] != exp_q[i]) d++;
    return d;
  endfunction

  function automatic int rd_diffs(input bit expect_data);
    int d = 0;
    if (!expect_data) return (rd_got.size() == 0) ? 0 : -1;
    if (rd_got.size() != rd_exp.size()) return -1;
    foreach (rd_got[i]) if (rd_got[i] !== rd_exp[i]) d++;
    return d;
  endfunction

  // Runs one transfer: m_start in cycle 0, slave behaviour per knobs, observes until m_done.
  task automatic run_txn(input bit md, input logic [ADDR_W-1:0] a,
                         input logic [BURST_W-1:0] bl, input bit ack_v, input int budget);
    int n = 0, first_mv = -1, split_left = 0, rst_state = 0, rd_acc = 0;
    bit split_fired = 1'b0, prev_stall = 1'b0, prev_bit = 1'b0;
    bits_q.delete(); rd_got.delete();
    wr_acks = 0; backoffs = 0; done_cyc = -1; stall_bad = 0; split_bad = 0; split_cyc = 0;
    done_seen = 1'b0; rst_done = 1'b0; got_err = 2'b11; rst_snap = '1;
    while (!done_seen && n < budget) begin
      @(posedge clk); #1;
      m_start = (n == 0); m_mode = md; m_addr = a; m_burst_len = bl; ack = ack_v;
      m_wr_data = (wr_acks < wdata.size()) ? wdata[wr_acks] : '0;
      if (rst_state == 1) begin rst = 1'b1; rst_state = 2; end
      else if (rst_state == 2) begin rst = 1'b0; rst_state = 3; end
      else rst = 1'b0;
      if (first_mv < 0 && master_valid) first_mv = n;
      bgrant = (int'($urandom_range(99)) < grant_pct);
      if (first_mv >= 0 && n - first_mv < rdy_hold0) slave_ready = 1'b0;
      else slave_ready = (int'($urandom_range(99)) < rdy_pct);
      if (split_at3) split = (split_left > 0);
      else split = (int'($urandom_range(99)) < split_pct);
      slave_valid = (int'($urandom_range(99)) < val_pct);
      rd_bus = (rd_src.size() > 0) ? rd_src[0] : 1'b0;
      @(negedge clk);
      if (master_valid && slave_ready) bits_q.push_back(wr_bus);
      if (prev_stall && master_valid && wr_bus !== prev_bit) stall_bad++;
      prev_stall = master_valid && !slave_ready;
      prev_bit = wr_bus;
      if (master_ready && slave_valid && !split && rd_src.size() > 0) begin
        void'(rd_src.pop_front());
        rd_acc++;
      end
      if (split_at3) begin
        if (split_left > 0) begin
          if (split_left < 10 && (master_ready !== 1'b0 || breq !== 1'b1)) split_bad++;
          split_left--;
          split_cyc++;
        end else if (!split_fired && rd_acc == 3) begin
          split_left = 10;
          split_fired = 1'b1;
        end
      end
      if (m_rd_valid) rd_got.push_back(m_rd_data);
      if (m_wr_ack) wr_acks++;
      if (m_busy && !breq && !m_done) backoffs++;
      if (rst_at_bit > 0 && rst_state == 0 && bits_q.size() == ADDR_W + rst_at_bit) rst_state = 1;
      if (rst_state == 3) begin
        rst_snap = {wr_bus, master_valid, master_ready, breq, m_busy, m_done, m_err,
                    m_rd_valid, m_wr_ack, mode, m_rd_data};
        rst_done = 1'b1;
        rst_state = 4;
      end
      if (m_done) begin done_seen = 1'b1; done_cyc = n; got_err = m_err; end
      n++;
    end
    split = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [18:0] snap;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    snap = {wr_bus, master_valid, master_ready, breq, m_busy, m_done, m_err,
            m_rd_valid, m_wr_ack, mode, m_rd_data};
    n_cmp++; if (snap !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h, need 0", snap); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (m_busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle: busy %b, need 0", m_busy); end
  endtask

  task automatic test_write_single();
    int d;
    nominal();
    wdata = '{8'hA5}; rd_exp.delete();
    model(1'b1, 16'h1234, 1'b1);
    run_txn(1'b1, 16'h1234, 4'd0, 1'b1, 200);
    d = bit_diffs();
    n_cmp++; if (d != 0) begin n_bad++; $display("FAIL wr1_bits: diffs %0d (got %0d bits, need %0d)", d, bits_q.size(), exp_q.size()); end
    n_cmp++; if (done_cyc != lat_model(1'b1, 1)) begin n_bad++; $display("FAIL wr1_latency: done cycle %0d, need %0d", done_cyc, lat_model(1'b1, 1)); end
    n_cmp++; if (done_cyc != 28) begin n_bad++; $display("FAIL wr1_cycle28: done cycle %0d, need 28", done_cyc); end
    n_cmp++; if (got_err !== 2'b00) begin n_bad++; $display("FAIL wr1_err: got %b, need 00", got_err); end
    n_cmp++; if (wr_acks != 1) begin n_bad++; $display("FAIL wr1_acks: got %0d, need 1", wr_acks); end
  endtask

  task automatic test_read_burst();
    int d;
    nominal();
    wdata.delete(); rd_exp = '{8'h11, 8'h22, 8'h33};
    model(1'b0, 16'hBEEF, 1'b1);
    run_txn(1'b0, 16'hBEEF, 4'd2, 1'b1, 300);
    d = rd_diffs(1'b1);
    n_cmp++; if (d != 0) begin n_bad++; $display("FAIL rd3_data: diffs %0d, got %0d beats, need 3", d, rd_got.size()); end
    d = bit_diffs();
    n_cmp++; if (d != 0) begin n_bad++; $display("FAIL rd3_addr_bits: diffs %0d (got %0d bits, need %0d)", d, bits_q.size(), exp_q.size()); end
    n_cmp++; if (got_err !== 2'b00 || !done_seen) begin n_bad++; $display("FAIL rd3_err: got %b done %b, need 00 done 1", got_err, done_seen); end
    n_cmp++; if (done_cyc != lat_model(1'b0, 3)) begin n_bad++; $display("FAIL rd3_latency: done cycle %0d, need %0d", done_cyc, lat_model(1'b0, 3)); end
  endtask

  task automatic test_nack();
    int d;
    nominal();
    wdata = '{8'h3C}; rd_exp.delete();
    model(1'b1, 16'hA0F0, 1'b0);
    run_txn(1'b1, 16'hA0F0, 4'd0, 1'b0, 200);
    d = bit_diffs();
    n_cmp++; if (d != 0) begin n_bad++; $display("FAIL nack_bits: diffs %0d (got %0d bits, need %0d)", d, bits_q.size(), exp_q.size()); end
    n_cmp++; if (got_err !== 2'b01) begin n_bad++; $display("FAIL nack_err: got %b, need 01", got_err); end
    n_cmp++; if (done_cyc != 3 + DEV_W) begin n_bad++; $display("FAIL nack_latency: done cycle %0d, need %0d", done_cyc, 3 + DEV_W); end
    n_cmp++; if (wr_acks != 0) begin n_bad++; $display("FAIL nack_wr_ack: got %0d, need 0", wr_acks); end
    @(posedge clk); @(negedge clk);
    n_cmp++; if (m_err !== 2'b01 || m_busy !== 1'b0) begin n_bad++; $display("FAIL nack_err_hold: err %b busy %b, need 01 0", m_err, m_busy); end
  endtask

  task automatic test_timeout_retry();
    int d;
    nominal();
    rdy_hold0 = 70;
    wdata = '{8'($urandom)}; rd_exp.delete();
    model(1'b1, 16'h5A5A, 1'b1);
    run_txn(1'b1, 16'h5A5A, 4'd0, 1'b1, 400);
    d = bit_diffs();
    n_cmp++; if (d != 0) begin n_bad++; $display("FAIL retry_bits: diffs %0d (got %0d bits, need %0d)", d, bits_q.size(), exp_q.size()); end
    n_cmp++; if (got_err !== 2'b00 || !done_seen) begin n_bad++; $display("FAIL retry_err: got %b done %b, need 00 done 1", got_err, done_seen); end
    n_cmp++; if (backoffs != 1) begin n_bad++; $display("FAIL retry_backoffs: got %0d, need 1", backoffs); end
    nominal();
    rdy_hold0 = 100000;
    model(1'b1, 16'h5A5A, 1'b1);
    run_txn(1'b1, 16'h5A5A, 4'd0, 1'b1, 600);
    n_cmp++; if (got_err !== 2'b10 || !done_seen) begin n_bad++; $display("FAIL tmo_err: got %b done %b, need 10 done 1", got_err, done_seen); end
    n_cmp++; if (backoffs != MAX_RETRY + 1) begin n_bad++; $display("FAIL tmo_backoffs: got %0d, need %0d", backoffs, MAX_RETRY + 1); end
    n_cmp++; if (done_cyc != (MAX_RETRY + 1) * (TIMEOUT + 3) + 1) begin n_bad++; $display("FAIL tmo_latency: done cycle %0d, need %0d", done_cyc, (MAX_RETRY + 1) * (TIMEOUT + 3) + 1); end
    n_cmp++; if (bits_q.size() != 0 || wr_acks != 0) begin n_bad++; $display("FAIL tmo_no_traffic: bits %0d acks %0d, need 0 0", bits_q.size(), wr_acks); end
  endtask

  task automatic test_split();
    int d;
    nominal();
    split_at3 = 1'b1;
    wdata.delete(); rd_exp = '{8'h5C};
    model(1'b0, 16'h0F1E, 1'b1);
    run_txn(1'b0, 16'h0F1E, 4'd0, 1'b1, 300);
    d = rd_diffs(1'b1);
    n_cmp++; if (d != 0) begin n_bad++; $display("FAIL split_data: diffs %0d, got %0d beats, need 1 (5c)", d, rd_got.size()); end
    n_cmp++; if (split_cyc != 10 || split_bad != 0) begin n_bad++; $display("FAIL split_hold: split cycles %0d bad %0d, need 10 0", split_cyc, split_bad); end
    n_cmp++; if (got_err !== 2'b00 || !done_seen) begin n_bad++; $display("FAIL split_err: got %b done %b, need 00 done 1", got_err, done_seen); end
  endtask

  task automatic test_reset_mid();
    int d;
    nominal();
    rst_at_bit = 5;
    wdata = '{8'hC3}; rd_exp.delete();
    model(1'b1, 16'h2468, 1'b1);
    run_txn(1'b1, 16'h2468, 4'd0, 1'b1, 80);
    n_cmp++; if (!rst_done || rst_snap !== '0) begin n_bad++; $display("FAIL rstmid_outputs: seen %b snap %h, need 1 0", rst_done, rst_snap); end
    n_cmp++; if (done_seen) begin n_bad++; $display("FAIL rstmid_no_done: m_done seen at cycle %0d, need none", done_cyc); end
    nominal();
    wdata = '{8'h96};
    model(1'b1, 16'h2468, 1'b1);
    run_txn(1'b1, 16'h2468, 4'd0, 1'b1, 200);
    d = bit_diffs();
    n_cmp++; if (d != 0 || done_cyc != lat_model(1'b1, 1) || got_err !== 2'b00) begin n_bad++; $display("FAIL rstmid_after: diffs %0d done %0d err %b, need 0 %0d 00", d, done_cyc, got_err, lat_model(1'b1, 1)); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 12; t++) begin
      bit md = 1'($urandom);
      bit ack_v = ($urandom_range(5) != 0);
      logic [ADDR_W-1:0] a = ADDR_W'($urandom);
      logic [BURST_W-1:0] bl = BURST_W'($urandom_range(3));
      int d, r;
      nominal();
      grant_pct = 70; rdy_pct = 70; val_pct = 70; split_pct = md ? 0 : 8;
      wdata.delete(); rd_exp.delete();
      for (int k = 0; k <= int'(bl); k++) begin
        wdata.push_back(DATA_W'($urandom));
        rd_exp.push_back(DATA_W'($urandom));
      end
      if (!md) wdata.delete();
      model(md, a, ack_v);
      run_txn(md, a, bl, ack_v, 800);
      d = bit_diffs();
      r = rd_diffs(!md && ack_v);
      n_cmp++; if (d != 0) begin n_bad++; $display("FAIL rand%0d_bits: diffs %0d (got %0d bits, need %0d)", t, d, bits_q.size(), exp_q.size()); end
      n_cmp++; if (r != 0) begin n_bad++; $display("FAIL rand%0d_rdata: diffs %0d, got %0d beats", t, r, rd_got.size()); end
      n_cmp++; if (!done_seen || got_err !== (ack_v ? 2'b00 : 2'b01)) begin n_bad++; $display("FAIL rand%0d_err: got %b done %b, need %b", t, got_err, done_seen, ack_v ? 2'b00 : 2'b01); end
      n_cmp++; if (wr_acks != ((md && ack_v) ? int'(bl) + 1 : 0)) begin n_bad++; $display("FAIL rand%0d_wr_acks: got %0d, need %0d", t, wr_acks, (md && ack_v) ? int'(bl) + 1 : 0); end
      n_cmp++; if (stall_bad != 0) begin n_bad++; $display("FAIL rand%0d_stall_stable: %0d changes while stalled, need 0", t, stall_bad); end
    end
  endtask

  initial begin
    nominal();
    test_reset();
    test_write_single();
    test_read_burst();
    test_nack();
    test_timeout_retry();
    test_split();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
